inst_cache: RTL

Direct-mapped, one-word-per-line instruction cache between the IF stage and the memory arbiter. It accepts word fetch requests from IF, answers hits from an internal register array, and on a miss refills the line with four byte reads over the byte-wide memory port before returning the word. It drives IF's `ram_inst` and `ram_inst_busy` inputs and shares the RAM with the data side through the arbiter's grant.

---
 rtl/inst_cache.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache for the IF stage.
// Misses refill the line with four byte reads over the arbitrated byte-wide RAM port.
module inst_cache #(
    parameter int unsigned INDEX_BITS = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        inst_re,
    input  logic [31:0] inst_addr,
    input  logic        flush,
    output logic [31:0] inst_out,
    output logic        inst_busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_din
);

    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = 30 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL} state_t;

    state_t state_q, state_d;
    logic [31:2] addr_q, addr_d;
    logic [2:0]  ic_q, ic_d;
    logic [1:0]  rc_q, rc_d;
    logic        pend_q, pend_d;
    logic        suppress_q, suppress_d;
    logic [31:0] word_q, word_d;
    logic [31:0] out_d;
    logic        busy_d, req_d;
    logic [31:0] maddr_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic        line_we;
    logic        hit;

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic                  unused_addr_bits;

    assign idx = addr_q[1+INDEX_BITS:2];
    assign tag = addr_q[31:2+INDEX_BITS];
    assign unused_addr_bits = ^inst_addr[1:0];
    // A flush on the lookup edge forces a miss even if the line was valid.
    assign hit = valid_q[idx] && (tag_mem[idx] == tag) && !flush;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ic_d       = ic_q;
        rc_d       = rc_q;
        pend_d     = 1'b0;
        suppress_d = suppress_q;
        word_d     = word_q;
        out_d      = inst_out;
        busy_d     = inst_busy;
        req_d      = mem_req;
        maddr_d    = mem_addr;
        valid_d    = valid_q;
        line_we    = 1'b0;
        case (state_q)
            IDLE: begin
                suppress_d = 1'b0;
                if (flush) valid_d = '0;
                if (inst_re) begin
                    addr_d  = inst_addr[31:2];
                    busy_d  = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (flush) valid_d = '0;
                if (hit) begin
                    out_d   = data_mem[idx];
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    req_d   = 1'b1;
                    ic_d    = '0;
                    rc_d    = '0;
                    maddr_d = {addr_q, 2'b00};
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (flush) begin
                    valid_d    = '0;
                    suppress_d = 1'b1;
                end
                if (mem_gnt && (ic_q < 3'd4)) begin
                    ic_d   = ic_q + 3'd1;
                    pend_d = 1'b1;
                end
                maddr_d = {addr_q, ic_d[1:0]};
                req_d   = (ic_d < 3'd4);
                // The byte for an address granted last cycle is on mem_din now.
                if (pend_q) begin
                    word_d[{rc_q, 3'b000} +: 8] = mem_din;
                    rc_d = rc_q + 2'd1;
                    if (rc_q == 2'd3) begin
                        out_d      = word_d;
                        busy_d     = 1'b0;
                        req_d      = 1'b0;
                        state_d    = IDLE;
                        line_we    = !suppress_q && !flush;
                        suppress_d = 1'b0;
                        if (line_we) valid_d[idx] = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            ic_q       <= '0;
            rc_q       <= '0;
            pend_q     <= 1'b0;
            suppress_q <= 1'b0;
            word_q     <= '0;
            inst_out   <= '0;
            inst_busy  <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            valid_q    <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ic_q       <= ic_d;
            rc_q       <= rc_d;
            pend_q     <= pend_d;
            suppress_q <= suppress_d;
            word_q     <= word_d;
            inst_out   <= out_d;
            inst_busy  <= busy_d;
            mem_req    <= req_d;
            mem_addr   <= maddr_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && line_we) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= word_d;
        end
    end

endmodule
